// File: rtl/mdu.sv
// rtl/mdu.sv - execute-stage multi-cycle multiply/divide unit with HI/LO registers
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] numa,
   input  logic [31:0] numb,
   input  logic [31:0] ir_e,
   output logic        start,
   output logic        busy,
   output logic [31:0] mdout
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [31:0]   hi, lo, pend_hi, pend_lo;
   logic          pend_keep;
   logic          commit;

   // Instruction decode: only SPECIAL-opcode words carry mult/div/move functions
   logic       r_type;
   logic [5:0] funct;
   logic       is_mult, is_multu, is_div, is_divu;
   logic       is_mfhi, is_mthi, is_mflo, is_mtlo, is_md;
   logic       unused_bits;

   assign r_type      = (ir_e[31:26] == 6'b000000);
   assign funct       = ir_e[5:0];
   assign unused_bits = ^ir_e[25:6];
   assign is_mult     = r_type && (funct == 6'b011000);
   assign is_multu    = r_type && (funct == 6'b011001);
   assign is_div      = r_type && (funct == 6'b011010);
   assign is_divu     = r_type && (funct == 6'b011011);
   assign is_mfhi     = r_type && (funct == 6'b010000);
   assign is_mthi     = r_type && (funct == 6'b010001);
   assign is_mflo     = r_type && (funct == 6'b010010);
   assign is_mtlo     = r_type && (funct == 6'b010011);
   assign is_md       = is_mult | is_multu | is_div | is_divu;

   assign busy   = (state == S_BUSY);
   assign start  = is_md & ~busy;
   assign commit = busy && (cnt == CW'(1));

   // Only committed HI/LO are ever visible; the pending result stays private
   assign mdout = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

   // Arithmetic: 64-bit products of the extended operands give signed/unsigned results
   logic [63:0] prod_s, prod_u;
   logic        b_nz;
   logic [31:0] abs_a, abs_b, abs_b_safe, numb_safe;
   logic [31:0] uq, ur, mq, mr, sq, sr;

   assign prod_s = {{32{numa[31]}}, numa} * {{32{numb[31]}}, numb};
   assign prod_u = {32'd0, numa} * {32'd0, numb};

   // Divisors are forced to 1 when zero so the divider never sees 0; the result is discarded anyway
   assign b_nz       = (numb != 32'd0);
   assign abs_a      = numa[31] ? (~numa + 32'd1) : numa;
   assign abs_b      = numb[31] ? (~numb + 32'd1) : numb;
   assign abs_b_safe = b_nz ? abs_b : 32'd1;
   assign numb_safe  = b_nz ? numb : 32'd1;
   assign uq         = numa / numb_safe;
   assign ur         = numa % numb_safe;
   assign mq         = abs_a / abs_b_safe;
   assign mr         = abs_a % abs_b_safe;
   // Magnitude divide then re-sign: truncation toward zero, remainder follows the dividend.
   // 0x80000000 / -1 falls out as LO=0x80000000, HI=0 with no special case.
   assign sq         = (numa[31] ^ numb[31]) ? (~mq + 32'd1) : mq;
   assign sr         = numa[31] ? (~mr + 32'd1) : mr;

   logic [31:0] res_hi, res_lo;

   // Select the result of the operation being accepted
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      if (is_mult) begin
         res_hi = prod_s[63:32];
         res_lo = prod_s[31:0];
      end else if (is_multu) begin
         res_hi = prod_u[63:32];
         res_lo = prod_u[31:0];
      end else if (is_div) begin
         res_hi = sr;
         res_lo = sq;
      end else if (is_divu) begin
         res_hi = ur;
         res_lo = uq;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next state: idle until an op is accepted, busy until the counter reaches 1
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start)  state_next = S_BUSY;
         S_BUSY:  if (commit) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Counter, pending result latch, HI/LO commit and mthi/mtlo writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_keep <= 1'b0;
      end else if (start) begin
         pend_hi   <= res_hi;
         pend_lo   <= res_lo;
         pend_keep <= (is_div | is_divu) & ~b_nz;
         cnt       <= (is_mult | is_multu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (busy) begin
         if (commit) begin
            cnt <= '0;
            if (!pend_keep) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else begin
         if (is_mthi) hi <= numa;
         if (is_mtlo) lo <= numa;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu
module tb_mdu;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] numa, numb, ir_e;
   logic        start, busy;
   logic [31:0] mdout;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .numa  (numa),
      .numb  (numb),
      .ir_e  (ir_e),
      .start (start),
      .busy  (busy),
      .mdout (mdout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  fn;
      logic [31:0] a, b, hi, lo;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
   } res_t;

   vec_t        vecs[8];
   res_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   function automatic logic [31:0] rtype(input logic [5:0] fn);
      return {26'd0, fn};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Counts consecutive busy cycles, sampling 1ns after each falling edge
   task automatic count_busy(output int n);
      bit done;
      n    = 0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         #1;
         if (!busy) done = 1;
         else begin
            n++;
            @(negedge clk);
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL busy_timeout: got busy=1 after 200 cycles expected busy=0");
      end
   endtask

   // Pops the oldest expected result and reads it back through mfhi/mflo
   task automatic finish_op(input string name);
      res_t r;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_scoreboard: got empty queue expected entry", name);
      end else begin
         r = sb.pop_front();
         @(negedge clk); ir_e = rtype(F_MFHI);
         #1 check({name, "_hi"}, mdout, r.hi);
         @(negedge clk); ir_e = rtype(F_MFLO);
         #1 check({name, "_lo"}, mdout, r.lo);
         model_hi = r.hi;
         model_lo = r.lo;
         @(negedge clk); ir_e = 32'd0;
      end
   endtask

   task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
      int   n;
      res_t r;
      @(negedge clk);
      ir_e = rtype(fn); numa = a; numb = b;
      #1 check({name, "_start"}, start, 1);
      r.hi = ehi; r.lo = elo;
      sb.push_back(r);
      @(negedge clk); ir_e = 32'd0;
      count_busy(n);
      check({name, "_busy_len"}, n, cyc);
      finish_op(name);
   endtask

   initial begin
      int   n;
      int   hits;
      res_t r;

      vecs[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vecs[1] = '{F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3] = '{F_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
      vecs[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[5] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[6] = '{F_DIV,   32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
      vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

      reset = 1'b1; ir_e = 32'd0; numa = 32'd0; numb = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 check("rst_busy", busy, 0);
      check("rst_start", start, 0);
      @(negedge clk); ir_e = rtype(F_MFHI);
      #1 check("rst_mfhi", mdout, 0);
      @(negedge clk); ir_e = rtype(F_MFLO);
      #1 check("rst_mflo", mdout, 0);
      @(negedge clk); ir_e = 32'd0;

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);

      // multu with an mfhi and mthi leaking into E while busy
      @(negedge clk);
      ir_e = rtype(F_MULTU); numa = 32'hFFFFFFFF; numb = 32'd2;
      #1 check("mu_start", start, 1);
      r.hi = 32'h00000001; r.lo = 32'hFFFFFFFE;
      sb.push_back(r);
      @(negedge clk); ir_e = rtype(F_MFHI);
      #1 check("mu_old_hi", mdout, model_hi);
      @(negedge clk); ir_e = rtype(F_MTHI); numa = 32'hDEADBEEF;
      @(negedge clk); ir_e = 32'd0;
      count_busy(n);
      check("mu_busy_rest", n, 3);
      finish_op("mu");

      // mthi then divide by zero: HI/LO must survive the commit
      @(negedge clk); ir_e = rtype(F_MTHI); numa = 32'h12345678;
      @(negedge clk); ir_e = rtype(F_MFHI);
      #1 check("mthi_vis", mdout, 32'h12345678);
      model_hi = 32'h12345678;
      run_op("div0", F_DIV, 32'd5, 32'd0, 32'h12345678, model_lo, 10);

      // Back-to-back: second mult on busy's last cycle is ignored, accepted next cycle
      @(negedge clk);
      ir_e = rtype(F_MULT); numa = 32'd3; numb = 32'd5;
      #1 check("b2b_a_start", start, 1);
      r.hi = 32'd0; r.lo = 32'd15;
      sb.push_back(r);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 5) begin
            ir_e = rtype(F_MULT); numa = 32'hFFFFFFFF; numb = 32'hFFFFFFFF;
            #1 check("b2b_last_busy", busy, 1);
            check("b2b_ignored", start, 0);
         end else begin
            ir_e = 32'd0;
         end
      end
      @(negedge clk);
      #1 check("b2b_busy_fell", busy, 0);
      check("b2b_b_start", start, 1);
      r.hi = 32'd0; r.lo = 32'd1;
      sb.push_back(r);
      r = sb.pop_front();
      @(negedge clk); ir_e = rtype(F_MFHI);
      #1 check("b2b_a_hi", mdout, r.hi);
      @(negedge clk); ir_e = rtype(F_MFLO);
      #1 check("b2b_a_lo", mdout, r.lo);
      model_hi = r.hi; model_lo = r.lo;
      @(negedge clk); ir_e = 32'd0;
      count_busy(n);
      check("b2b_b_busy_rest", n, 3);
      finish_op("b2b_b");

      // div 100/7 aborted by reset in the 4th busy cycle
      @(negedge clk);
      ir_e = rtype(F_DIV); numa = 32'd100; numb = 32'd7;
      #1 check("rst_div_start", start, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); ir_e = 32'd0;
         #1 check($sformatf("rst_div_busy%0d", k), busy, 1);
      end
      #1 reset = 1'b1;
      #1 check("rst_mid_busy", busy, 0);
      #1 reset = 1'b0;
      model_hi = 32'd0; model_lo = 32'd0;
      hits = 0;
      repeat (15) begin
         @(negedge clk);
         #1 if (busy) hits++;
      end
      check("rst_no_busy", hits, 0);
      @(negedge clk); ir_e = rtype(F_MFHI);
      #1 check("rst_mid_hi", mdout, model_hi);
      @(negedge clk); ir_e = rtype(F_MFLO);
      #1 check("rst_mid_lo", mdout, model_lo);
      @(negedge clk); ir_e = 32'd0;

      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
